// File: rtl/system1_majority_pkg.sv
// Shared constants and the 2-of-3 vote function for the triplicated-bit voter.
package system1_pkg;

  localparam int V1_IDX = 0;
  localparam int V2_IDX = 1;
  localparam int V3_IDX = 2;
  localparam int N_VOTERS = 3;

  localparam int DEF_CNT_W        = 4;
  localparam int DEF_FAULT_THRESH = 3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/system1_majority_vote_fault_counter.sv
// Per-voter saturating consecutive-disagreement counter with a sticky fault flag.
module vote_fault_counter #(
  parameter int CNT_W        = 4,
  parameter int FAULT_THRESH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic disagree,
  output logic fault
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_next = '0;
    if (!clr && disagree) begin
      cnt_next = sat_inc(cnt);
    end
  end

  // The flag looks at the next count so it rises on the edge that registers
  // the threshold-th disagreement; clear overrides a same-cycle disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      fault <= clr ? 1'b0 : (fault | (cnt_next >= THRESH));
    end
  end

endmodule

// File: rtl/system1_majority.sv
// Registered 2-of-3 majority voter with disagreement, unanimity and sticky fault reporting.
module system1_majority
  import system1_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FAULT_THRESH = DEF_FAULT_THRESH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v1,
  input  logic       v2,
  input  logic       v3,
  input  logic       clr_fault,
  output logic       out,
  output logic [2:0] dis,
  output logic       unanimous,
  output logic [2:0] fault
);

  if (CNT_W < 1 || FAULT_THRESH < 1 || FAULT_THRESH > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("system1_majority: FAULT_THRESH=%0d outside 1..%0d", FAULT_THRESH, (2 ** CNT_W) - 1);
  end

  logic [N_VOTERS-1:0] votes;
  logic                maj;
  logic [N_VOTERS-1:0] dis_next;

  always_comb begin
    votes         = '0;
    votes[V1_IDX] = v1;
    votes[V2_IDX] = v2;
    votes[V3_IDX] = v3;
    maj           = maj3(v1, v2, v3);
    dis_next      = votes ^ {N_VOTERS{maj}};
  end

  // Output register stage: everything reflects the previous edge's inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 1'b0;
      dis       <= '0;
      unanimous <= 1'b0;
    end else begin
      out       <= maj;
      dis       <= dis_next;
      unanimous <= ~|dis_next;
    end
  end

  for (genvar i = 0; i < N_VOTERS; i++) begin : g_voter
    vote_fault_counter #(
      .CNT_W       (CNT_W),
      .FAULT_THRESH(FAULT_THRESH)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr_fault),
      .disagree(dis_next[i]),
      .fault   (fault[i])
    );
  end

endmodule

// File: tb/tb_system1_majority.sv
// Directed bench for the majority voter: sweep, fault counting, clear priority, saturation, async reset.
module tb_system1_majority;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v1, v2, v3, clr_fault;
  logic       out, unanimous;
  logic [2:0] dis, fault;
  logic       out_s, unanimous_s;
  logic [2:0] dis_s, fault_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  system1_majority dut (
    .clk(clk), .rst_n(rst_n), .v1(v1), .v2(v2), .v3(v3), .clr_fault(clr_fault),
    .out(out), .dis(dis), .unanimous(unanimous), .fault(fault)
  );

  system1_majority #(.CNT_W(2), .FAULT_THRESH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .v1(v1), .v2(v2), .v3(v3), .clr_fault(clr_fault),
    .out(out_s), .dis(dis_s), .unanimous(unanimous_s), .fault(fault_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // vec is written v1v2v3 (MSB = v1) to match the truth table notation.
  task automatic step(input logic [2:0] vec, input logic clr);
    v1 = vec[2]; v2 = vec[1]; v3 = vec[0]; clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] sweep_vec [7] = '{3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
  logic       sweep_out [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [2:0] sweep_dis [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
  logic [2:0] intr_vec  [5] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001};

  initial begin
    rst_n = 1'b0; v1 = 0; v2 = 0; v3 = 0; clr_fault = 0;
    repeat (2) @(posedge clk);
    v1 = 1; v2 = 1; v3 = 1;
    @(posedge clk); #1;
    chk("rst_out", out, 0);
    chk("rst_dis", dis, 0);
    chk("rst_unan", unanimous, 0);
    chk("rst_fault", fault, 0);

    @(negedge clk);
    v1 = 0; v2 = 0; v3 = 0;
    rst_n = 1'b1;
    step(3'b000, 0);
    chk("post_rst_out", out, 0);
    chk("post_rst_unan", unanimous, 1);
    chk("post_rst_dis", dis, 0);

    for (int i = 0; i < 7; i++) begin
      step(sweep_vec[i], 0);
      chk($sformatf("sweep_out_%0d", i), out, sweep_out[i]);
      chk($sformatf("sweep_dis_%0d", i), dis, sweep_dis[i]);
      chk($sformatf("sweep_unan_%0d", i), unanimous, (i == 6) ? 1 : 0);
    end
    chk("sweep_fault", fault, 0);

    for (int i = 0; i < 3; i++) begin
      step(3'b100, 0);
      chk($sformatf("run_dis_%0d", i), dis, 3'b001);
      chk($sformatf("run_fault_%0d", i), fault, (i == 2) ? 3'b001 : 3'b000);
    end
    step(3'b000, 0);
    chk("sticky_fault", fault, 3'b001);
    chk("sticky_cnt0", dut.g_voter[0].u_cnt.cnt, 0);
    chk("sticky_unan", unanimous, 1);

    step(3'b100, 1);
    chk("clr_fault", fault, 0);
    chk("clr_cnt0", dut.g_voter[0].u_cnt.cnt, 0);
    for (int i = 0; i < 3; i++) begin
      step(3'b100, 0);
      chk($sformatf("refault_%0d", i), fault, (i == 2) ? 3'b001 : 3'b000);
    end
    step(3'b000, 1);
    chk("clr2_fault", fault, 0);

    for (int i = 0; i < 5; i++) begin
      step(intr_vec[i], 0);
      chk($sformatf("intr_dis_%0d", i), dis, (i == 2) ? 3'b000 : 3'b100);
      chk($sformatf("intr_fault_%0d", i), fault, 0);
    end
    chk("intr_cnt2", dut.g_voter[2].u_cnt.cnt, 2);

    step(3'b000, 1);
    for (int i = 0; i < 10; i++) begin
      step(3'b010, 0);
      chk($sformatf("sat_cnt1_%0d", i), dut_sat.g_voter[1].u_cnt.cnt, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat_fault_%0d", i), fault_s, (i >= 2) ? 3'b010 : 3'b000);
      chk($sformatf("wide_cnt1_%0d", i), dut.g_voter[1].u_cnt.cnt, i + 1);
    end
    chk("sat_out", out_s, 0);
    chk("sat_dis", dis_s, 3'b010);

    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_dis", dis, 0);
    chk("mid_rst_unan", unanimous, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_fault_s", fault_s, 0);
    chk("mid_rst_dis_s", dis_s, 0);
    chk("mid_rst_cnt1_s", dut_sat.g_voter[1].u_cnt.cnt, 0);
    chk("mid_rst_cnt1", dut.g_voter[1].u_cnt.cnt, 0);

    @(negedge clk);
    rst_n = 1'b1;
    step(3'b010, 0);
    chk("restart_cnt1", dut.g_voter[1].u_cnt.cnt, 1);
    chk("restart_fault", fault, 0);
    step(3'b000, 0);
    chk("restart_unan", unanimous, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/system1_majority.md
Name: system1_majority

Overview:
- Registered 2-of-3 majority voter over three single-bit votes v1, v2, v3. Used as the redundancy-resolution point for triplicated control bits.
- Besides the voted result, it reports which voter disagreed in a given cycle and whether all voters agreed.
- It also raises a sticky per-voter fault flag once a voter disagrees for FAULT_THRESH consecutive cycles.

Parameters:
- CNT_W, 4, width of each per-voter consecutive-disagreement counter.
- FAULT_THRESH, 3, consecutive disagreement count at which fault[i] sets. Legal range 1 .. 2^CNT_W-1; an out-of-range value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- v1  in  1  vote from voter 1
- v2  in  1  vote from voter 2
- v3  in  1  vote from voter 3
- clr_fault  in  1  synchronous clear of fault flags and counters
- out  out  1  registered majority result
- dis  out  3  registered disagreement vector; bit0=v1, bit1=v2, bit2=v3
- unanimous  out  1  registered; 1 when v1==v2==v3
- fault  out  3  sticky fault flags, same bit order as dis

Behaviour:
- Majority (combinational): maj = (v1&v2) | (v1&v3) | (v2&v3).
- Truth table, v1v2v3 -> maj: 000->0, 100->0, 010->0, 110->1, 001->0, 101->1, 011->1, 111->1.
- Latency: out, dis and unanimous are registered. They reflect the inputs sampled at the previous rising edge (1-cycle latency).
- dis[i] = (vi != maj). At most one dis bit can be set in any cycle.
- unanimous = ~|dis.
- Reset (rst_n=0, asynchronous, immediate): out=0, dis=000, unanimous=0, fault=000, all counters=0. Outputs hold these values until the first rising edge after rst_n deasserts.
- Per-voter counter cnt[i], updated each rising edge:
  - if clr_fault=1: cnt[i] <= 0;
  - else if vi != maj: cnt[i] <= cnt[i]+1, saturating at 2^CNT_W-1 (never wraps);
  - else: cnt[i] <= 0.
- Fault flag, updated each rising edge:
  - if clr_fault=1: fault[i] <= 0, even if voter i disagrees that same cycle (clear wins);
  - else fault[i] <= fault[i] | (next cnt[i] >= FAULT_THRESH).
  - fault[i] is therefore asserted on the same edge that registers the FAULT_THRESH-th consecutive disagreement.
- Faults are sticky: once set, fault[i] stays high until clr_fault or reset, even after voter i agrees again.
- A faulted voter still participates in the vote; there is no masking.
- Reset asserted mid-operation discards all history; counting restarts from 0 after release.
- No X-propagation handling is required. Inputs are synchronous to clk.

Decomposition:
- Package system1_pkg:
  - localparams for voter indices (V1_IDX=0, V2_IDX=1, V3_IDX=2);
  - default values for CNT_W and FAULT_THRESH;
  - a function maj3(a,b,c).
- One sub-module, vote_fault_counter, instantiated three times.
  - Inputs: clk, rst_n, clr, disagree.
  - Parameters: CNT_W, FAULT_THRESH.
  - Output: fault.
  - Holds the saturating counter and the sticky flag.
- The top level holds the majority logic and the output registers.

Test Plan:
- Reset: hold rst_n=0 with inputs 000, then apply 111 while still in reset -> out=0, dis=000, unanimous=0, fault=000. After release with 000 and one edge -> out=0, unanimous=1.
- Full sweep, one edge per vector, in order 100, 010, 110, 001, 101, 011, 111 -> out one cycle later = 0,0,1,0,1,1,1; dis = 001,010,100,100,010,001,000; unanimous only on 111.
- Consecutive fault: v1=1, v2=0, v3=0 held for 3 edges -> dis=001 each cycle, fault=001 after the 3rd edge. Then apply 000 -> fault stays 001, while cnt[0] returns to 0.
- Interrupted run: v3 disagrees 2 cycles, agrees 1 cycle, disagrees 2 cycles -> fault[2] never sets.
- clr_fault priority: with fault=001, assert clr_fault while v1 still disagrees -> fault=000 and cnt[0]=0 after that edge. Keep disagreeing -> fault re-sets 3 edges after clr_fault drops.
- Saturation, with FAULT_THRESH=3 and CNT_W=2: v2 disagrees for 10 cycles -> cnt[1] holds at 3 without wrapping, fault=010. Then assert rst_n=0 mid-run -> all outputs clear immediately, before the next clock edge.
